fft_frame_serializer: RTL and testbench

FFT_FRAME_SERIALIZER -- requirements
Module: fft_frame_serializer

---
 rtl/fft_frame_serializer.sv | 117 +++++++++++
 tb/tb_fft_frame_serializer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_serializer.sv
// Captures a 16-bin complex FFT frame in one cycle and streams it out bin by bin
// over a valid/ready port, with seamless back-to-back frames and drop signalling.
module fft_frame_serializer #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] in0_re,  input  logic [N-1:0] in1_re,
    input  logic [N-1:0] in2_re,  input  logic [N-1:0] in3_re,
    input  logic [N-1:0] in4_re,  input  logic [N-1:0] in5_re,
    input  logic [N-1:0] in6_re,  input  logic [N-1:0] in7_re,
    input  logic [N-1:0] in8_re,  input  logic [N-1:0] in9_re,
    input  logic [N-1:0] in10_re, input  logic [N-1:0] in11_re,
    input  logic [N-1:0] in12_re, input  logic [N-1:0] in13_re,
    input  logic [N-1:0] in14_re, input  logic [N-1:0] in15_re,
    input  logic [N-1:0] in0_im,  input  logic [N-1:0] in1_im,
    input  logic [N-1:0] in2_im,  input  logic [N-1:0] in3_im,
    input  logic [N-1:0] in4_im,  input  logic [N-1:0] in5_im,
    input  logic [N-1:0] in6_im,  input  logic [N-1:0] in7_im,
    input  logic [N-1:0] in8_im,  input  logic [N-1:0] in9_im,
    input  logic [N-1:0] in10_im, input  logic [N-1:0] in11_im,
    input  logic [N-1:0] in12_im, input  logic [N-1:0] in13_im,
    input  logic [N-1:0] in14_im, input  logic [N-1:0] in15_im,
    output logic [N-1:0] out_re,
    output logic [N-1:0] out_im,
    output logic [3:0]   out_idx,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         busy,
    output logic         drop
);

    // Handshake: a bin moves downstream on every rising edge where out_valid and
    // out_ready are both 1; while out_valid=1 and out_ready=0 all outputs hold.
    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t       state, state_nx;
    logic [3:0]   idx, idx_nx;
    logic         drop_q;
    logic [N-1:0] bank_re [16];
    logic [N-1:0] bank_im [16];
    logic [N-1:0] in_re   [16];
    logic [N-1:0] in_im   [16];
    logic         xfer, at_last, capture, reject;

    assign in_re[0]  = in0_re;  assign in_re[1]  = in1_re;
    assign in_re[2]  = in2_re;  assign in_re[3]  = in3_re;
    assign in_re[4]  = in4_re;  assign in_re[5]  = in5_re;
    assign in_re[6]  = in6_re;  assign in_re[7]  = in7_re;
    assign in_re[8]  = in8_re;  assign in_re[9]  = in9_re;
    assign in_re[10] = in10_re; assign in_re[11] = in11_re;
    assign in_re[12] = in12_re; assign in_re[13] = in13_re;
    assign in_re[14] = in14_re; assign in_re[15] = in15_re;
    assign in_im[0]  = in0_im;  assign in_im[1]  = in1_im;
    assign in_im[2]  = in2_im;  assign in_im[3]  = in3_im;
    assign in_im[4]  = in4_im;  assign in_im[5]  = in5_im;
    assign in_im[6]  = in6_im;  assign in_im[7]  = in7_im;
    assign in_im[8]  = in8_im;  assign in_im[9]  = in9_im;
    assign in_im[10] = in10_im; assign in_im[11] = in11_im;
    assign in_im[12] = in12_im; assign in_im[13] = in13_im;
    assign in_im[14] = in14_im; assign in_im[15] = in15_im;

    // A load is only taken when idle or exactly as the last bin leaves.
    assign xfer    = (state == SEND) && out_ready;
    assign at_last = (idx == 4'd15);
    assign capture = load && ((state == IDLE) || (xfer && at_last));
    assign reject  = load && (state == SEND) && !(xfer && at_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= 4'd0;
            drop_q <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                bank_re[i] <= '0;
                bank_im[i] <= '0;
            end
        end else begin
            state  <= state_nx;
            idx    <= idx_nx;
            drop_q <= reject;
            if (capture) begin
                for (int i = 0; i < 16; i++) begin
                    bank_re[i] <= in_re[i];
                    bank_im[i] <= in_im[i];
                end
            end
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        case (state)
            IDLE: if (load) state_nx = SEND;
            SEND: if (xfer && at_last) state_nx = load ? SEND : IDLE;
            default: state_nx = IDLE;
        endcase
        if (capture)
            idx_nx = 4'd0;
        else if (xfer)
            idx_nx = at_last ? 4'd0 : idx + 4'd1;
    end

    always_comb begin
        out_valid = (state == SEND);
        busy      = (state == SEND);
        out_last  = (state == SEND) && at_last;
        out_idx   = idx;
        out_re    = bank_re[idx];
        out_im    = bank_im[idx];
        drop      = drop_q;
    end

endmodule

// File: tb/tb_fft_frame_serializer.sv
// Bench for fft_frame_serializer: scenario tasks feed frames, push expected bins
// to a queue and compare each presented bin at the falling edge.
module tb_fft_frame_serializer;

    logic        clk = 1'b0;
    logic        rst, load, load8, out_ready;
    logic [15:0] fre [16];
    logic [15:0] fim [16];
    logic [15:0] out_re, out_im;
    logic [3:0]  out_idx;
    logic        out_valid, out_last, busy, drop;
    logic [7:0]  re8, im8, out8_re, out8_im;
    logic [3:0]  out8_idx;
    logic        out8_valid, out8_last, busy8, drop8;

    logic [35:0] exp_q [$];
    logic [19:0] exp8_q [$];
    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fft_frame_serializer #(.N(16)) u_dut (
        .clk(clk), .rst(rst), .load(load),
        .in0_re(fre[0]),   .in1_re(fre[1]),   .in2_re(fre[2]),   .in3_re(fre[3]),
        .in4_re(fre[4]),   .in5_re(fre[5]),   .in6_re(fre[6]),   .in7_re(fre[7]),
        .in8_re(fre[8]),   .in9_re(fre[9]),   .in10_re(fre[10]), .in11_re(fre[11]),
        .in12_re(fre[12]), .in13_re(fre[13]), .in14_re(fre[14]), .in15_re(fre[15]),
        .in0_im(fim[0]),   .in1_im(fim[1]),   .in2_im(fim[2]),   .in3_im(fim[3]),
        .in4_im(fim[4]),   .in5_im(fim[5]),   .in6_im(fim[6]),   .in7_im(fim[7]),
        .in8_im(fim[8]),   .in9_im(fim[9]),   .in10_im(fim[10]), .in11_im(fim[11]),
        .in12_im(fim[12]), .in13_im(fim[13]), .in14_im(fim[14]), .in15_im(fim[15]),
        .out_re(out_re), .out_im(out_im), .out_idx(out_idx), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .busy(busy), .drop(drop)
    );

    fft_frame_serializer #(.N(8)) u_dut8 (
        .clk(clk), .rst(rst), .load(load8),
        .in0_re(re8),  .in1_re(re8),  .in2_re(re8),  .in3_re(re8),
        .in4_re(re8),  .in5_re(re8),  .in6_re(re8),  .in7_re(re8),
        .in8_re(re8),  .in9_re(re8),  .in10_re(re8), .in11_re(re8),
        .in12_re(re8), .in13_re(re8), .in14_re(re8), .in15_re(re8),
        .in0_im(im8),  .in1_im(im8),  .in2_im(im8),  .in3_im(im8),
        .in4_im(im8),  .in5_im(im8),  .in6_im(im8),  .in7_im(im8),
        .in8_im(im8),  .in9_im(im8),  .in10_im(im8), .in11_im(im8),
        .in12_im(im8), .in13_im(im8), .in14_im(im8), .in15_im(im8),
        .out_re(out8_re), .out_im(out8_im), .out_idx(out8_idx), .out_valid(out8_valid),
        .out_ready(out_ready), .out_last(out8_last), .busy(busy8), .drop(drop8)
    );

    // mode 0: re=k+1, im=-(k+1); mode 1: re=100+k, im=-(100+k); mode 2: random
    task automatic set_frame(input int mode, input bit push);
        for (int k = 0; k < 16; k++) begin
            case (mode)
                0:       begin fre[k] = 16'(k + 1);   fim[k] = 16'(-(k + 1)); end
                1:       begin fre[k] = 16'(100 + k); fim[k] = 16'(-(100 + k)); end
                default: begin fre[k] = 16'($urandom_range(0, 65535));
                               fim[k] = 16'($urandom_range(0, 65535)); end
            endcase
            if (push) exp_q.push_back({4'(k), fre[k], fim[k]});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b0; load8 = 1'b0; out_ready = 1'b1;
        re8 = 8'h00; im8 = 8'h00;
        set_frame(0, 1'b0);
        load = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({out_valid, busy, drop, out_last, out_idx, out_re, out_im} !== 40'd0) begin
            n_fail++;
            $display("FAIL reset16 got v=%b b=%b d=%b l=%b idx=%0d re=%h im=%h required all zero",
                     out_valid, busy, drop, out_last, out_idx, out_re, out_im);
        end
        n_cmp++;
        if ({out8_valid, busy8, drop8, out8_last, out8_idx, out8_re, out8_im} !== 24'd0) begin
            n_fail++;
            $display("FAIL reset8 got v=%b b=%b idx=%0d re=%h im=%h required all zero",
                     out8_valid, busy8, out8_idx, out8_re, out8_im);
        end
        load = 1'b0;
        rst  = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_capture got out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_basic();
        logic [35:0] e;
        set_frame(0, 1'b1);
        out_ready = 1'b1; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < 16; i++) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || drop !== 1'b0 ||
                {out_idx, out_re, out_im} !== e || out_last !== (i == 15)) begin
                n_fail++;
                $display("FAIL basic bin=%0d got v=%b idx=%0d re=%h im=%h last=%b required idx=%0d re=%h im=%h last=%b",
                         i, out_valid, out_idx, out_re, out_im, out_last, e[35:32], e[31:16], e[15:0], i == 15);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_end got v=%b busy=%b last=%b required 0 0 0", out_valid, busy, out_last);
        end
    endtask

    // ready pattern 1,0,0,1,0,0,...: the head of the queue must stay on the port while stalled
    task automatic test_stall(input bit rnd);
        int got, c;
        set_frame(rnd ? 2 : 0, 1'b1);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        got = 0; c = 0;
        while (got < 16 && c < 200) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : (c % 3 == 0);
            n_cmp++;
            if (out_valid !== 1'b1 || {out_idx, out_re, out_im} !== exp_q[0] ||
                out_last !== (exp_q[0][35:32] == 4'd15)) begin
                n_fail++;
                $display("FAIL stall cyc=%0d got v=%b idx=%0d re=%h im=%h required idx=%0d re=%h im=%h",
                         c, out_valid, out_idx, out_re, out_im, exp_q[0][35:32], exp_q[0][31:16], exp_q[0][15:0]);
            end
            if (out_ready) begin
                void'(exp_q.pop_front());
                got++;
            end
            c++;
            @(negedge clk);
        end
        n_cmp++;
        if (got != 16 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_end got delivered=%0d v=%b required 16 0", got, out_valid);
        end
        exp_q.delete();
        out_ready = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [35:0] e;
        set_frame(0, 1'b1);
        out_ready = 1'b1; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < 32; i++) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || drop !== 1'b0 || {out_idx, out_re, out_im} !== e) begin
                n_fail++;
                $display("FAIL b2b step=%0d got v=%b b=%b d=%b idx=%0d re=%h im=%h required idx=%0d re=%h im=%h",
                         i, out_valid, busy, drop, out_idx, out_re, out_im, e[35:32], e[31:16], e[15:0]);
            end
            load = (i == 15);
            if (i == 15) set_frame(1, 1'b1);
            @(negedge clk);
        end
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end got v=%b busy=%b required 0 0", out_valid, busy);
        end
    endtask

    // rejected loads after bins 5, 9 and 10: drop on bins 6, 10 and 11 only
    task automatic test_drop();
        logic [35:0] e;
        set_frame(0, 1'b1);
        out_ready = 1'b1; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < 16; i++) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (drop !== (i == 6 || i == 10 || i == 11) || {out_idx, out_re, out_im} !== e) begin
                n_fail++;
                $display("FAIL drop bin=%0d got drop=%b idx=%0d re=%h im=%h required drop=%b idx=%0d re=%h im=%h",
                         i, drop, out_idx, out_re, out_im, (i == 6 || i == 10 || i == 11), e[35:32], e[31:16], e[15:0]);
            end
            load = (i == 5 || i == 9 || i == 10);
            if (load) set_frame(2, 1'b0);
            @(negedge clk);
        end
        n_cmp++;
        if (out_valid !== 1'b0 || drop !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_end got v=%b drop=%b required 0 0", out_valid, drop);
        end
    endtask

    task automatic test_reset_mid();
        logic [35:0] e;
        set_frame(0, 1'b1);
        out_ready = 1'b1; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int i = 0; i <= 8; i++) begin
            e = exp_q.pop_front();
            n_cmp++;
            if ({out_idx, out_re, out_im} !== e) begin
                n_fail++;
                $display("FAIL rstmid_pre bin=%0d got idx=%0d re=%h required idx=%0d re=%h",
                         i, out_idx, out_re, e[35:32], e[31:16]);
            end
            if (i == 8) begin
                rst = 1'b1; load = 1'b1;
                set_frame(1, 1'b0);
            end
            @(negedge clk);
        end
        rst = 1'b0; load = 1'b0;
        exp_q.delete();
        n_cmp++;
        if ({out_valid, busy, drop, out_idx, out_re, out_im} !== 39'd0) begin
            n_fail++;
            $display("FAIL rstmid got v=%b b=%b d=%b idx=%0d re=%h im=%h required all zero",
                     out_valid, busy, drop, out_idx, out_re, out_im);
        end
        set_frame(1, 1'b1);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < 16; i++) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (out_valid !== 1'b1 || {out_idx, out_re, out_im} !== e) begin
                n_fail++;
                $display("FAIL rstmid_restart bin=%0d got v=%b idx=%0d re=%h im=%h required idx=%0d re=%h im=%h",
                         i, out_valid, out_idx, out_re, out_im, e[35:32], e[31:16], e[15:0]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_n8();
        logic [19:0] e;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; load8 = 1'b1; out_ready = 1'b1;
        re8 = 8'h80; im8 = 8'h7f;
        for (int k = 0; k < 16; k++) exp8_q.push_back({4'(k), 8'h80, 8'h7f});
        @(negedge clk);
        load8 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            e = exp8_q.pop_front();
            n_cmp++;
            if (out8_valid !== 1'b1 || {out8_idx, out8_re, out8_im} !== e || out8_last !== (i == 15)) begin
                n_fail++;
                $display("FAIL n8 bin=%0d got v=%b idx=%0d re=%h im=%h last=%b required idx=%0d re=%h im=%h",
                         i, out8_valid, out8_idx, out8_re, out8_im, out8_last, e[19:16], e[15:8], e[7:0]);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (out8_valid !== 1'b0 || busy8 !== 1'b0) begin
            n_fail++;
            $display("FAIL n8_end got v=%b busy=%b required 0 0", out8_valid, busy8);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall(1'b0);
        test_stall(1'b1);
        test_back_to_back();
        test_drop();
        test_reset_mid();
        test_n8();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
